// File: rtl/edge_detection_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_detection_pkg
// Description : Shared constants and helpers for the edge_detection block.
//               sync_depth() maps a requested synchronizer depth onto the
//               supported set {0, 2, 3, 4}.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_detection_pkg;

  // Deepest synchronizer chain the block supports.
  localparam int c_MAX_SYNC_STAGES = 4;

  // Shallowest chain that still gives metastability protection.
  localparam int c_MIN_SYNC_STAGES = 2;

  // Maps a requested depth onto the supported set.
  // A negative or zero request means "input already synchronous".
  // A request of 1 is raised to the minimum safe depth.
  // Requests above the maximum are capped.
  function automatic int sync_depth(input int stages);
    int depth;
    depth = stages;
    if (stages <= 0) begin
      depth = 0;
    end else if (stages < c_MIN_SYNC_STAGES) begin
      depth = c_MIN_SYNC_STAGES;
    end else if (stages > c_MAX_SYNC_STAGES) begin
      depth = c_MAX_SYNC_STAGES;
    end
    return depth;
  endfunction

endpackage : edge_detection_pkg
`default_nettype wire

// File: rtl/edge_detection_sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : STAGES-deep flip-flop synchronizer, WIDTH bits wide.
//               Every stage clears to 0 on reset.
// Ports       : clk_i   - destination clock
//               rst_i   - asynchronous active-low reset
//               i_data  - asynchronous input vector
//               o_data  - synchronized output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/edge_detection.sv
`default_nettype none
// ============================================================================
// Module      : edge_detection
// Description : Per-bit edge detector. It turns level changes on 'signal'
//               into registered single-cycle pulses:
//               - 'rising' pulses on a 0->1 transition;
//               - 'failling' pulses on a 1->0 transition.
//               An optional synchronizer chain sits in front of the detector
//               for inputs that come from another clock domain.
// Ports       : clk_i    - clock, all state updates on the rising edge
//               rst_i    - asynchronous active-low reset
//               signal   - WIDTH level inputs to monitor
//               rising   - WIDTH one-cycle pulses on 0->1
//               failling - WIDTH one-cycle pulses on 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detection
  import edge_detection_pkg::*;
#(
  parameter int   WIDTH       = 1,
  parameter int   SYNC_STAGES = 0,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] signal,
  output logic [WIDTH-1:0] rising,
  output logic [WIDTH-1:0] failling
);

  localparam int c_DEPTH = sync_depth(SYNC_STAGES);

  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rising;
  logic [WIDTH-1:0] r_failling;

  generate
    if (c_DEPTH > 0) begin : g_sync
      sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (c_DEPTH)
      ) u_sync_chain (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_data (signal),
        .o_data (w_cur)
      );
    end else begin : g_no_sync
      assign w_cur = signal;
    end
  endgenerate

  // After reset, r_prev holds the assumed idle level.
  // A bit that differs from that level at the first edge produces one pulse.
  // The reset event itself produces no pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_prev     <= {WIDTH{RESET_LEVEL}};
      r_rising   <= '0;
      r_failling <= '0;
    end else begin
      r_prev     <= w_cur;
      r_rising   <= w_cur & ~r_prev;
      r_failling <= ~w_cur & r_prev;
    end
  end

  assign rising   = r_rising;
  assign failling = r_failling;

endmodule : edge_detection
`default_nettype wire

// File: tb/tb_edge_detection.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_detection
// Description : Directed self-checking bench for edge_detection.
//               Three instances share one clock and one reset:
//               - u_w4 : WIDTH=4, SYNC_STAGES=0, RESET_LEVEL=0
//               - u_rl1: WIDTH=1, SYNC_STAGES=0, RESET_LEVEL=1
//               - u_s2 : WIDTH=1, SYNC_STAGES=2, RESET_LEVEL=0
//               The expected outputs for each step are queued together with
//               the stimulus. They are popped and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_detection;

  logic       clk;
  logic       rst_n;
  logic [3:0] s0;
  logic [3:0] r0;
  logic [3:0] f0;
  logic       s1;
  logic       r1;
  logic       f1;
  logic       s2;
  logic       r2;
  logic       f2;

  int tests;
  int fails;

  typedef struct {
    string      tag;
    logic [3:0] r0;
    logic [3:0] f0;
    logic       r1;
    logic       f1;
    logic       r2;
    logic       f2;
  } exp_t;

  exp_t sb[$];

  edge_detection #(.WIDTH(4), .SYNC_STAGES(0), .RESET_LEVEL(1'b0)) u_w4 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .signal   (s0),
    .rising   (r0),
    .failling (f0)
  );

  edge_detection #(.WIDTH(1), .SYNC_STAGES(0), .RESET_LEVEL(1'b1)) u_rl1 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .signal   (s1),
    .rising   (r1),
    .failling (f1)
  );

  edge_detection #(.WIDTH(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) u_s2 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .signal   (s2),
    .rising   (r2),
    .failling (f2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: tests=%0d fails=%0d (simulation did not finish)", tests, fails);
    $fatal(1, "watchdog expired");
  end

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock step:
  //  1. drive the inputs at the falling edge;
  //  2. push the expected outputs for the following rising edge;
  //  3. pop and compare them just after that edge.
  task automatic cyc(input string tag, input logic rst, input logic [3:0] s0v,
                     input logic s1v, input logic s2v,
                     input logic [3:0] er0, input logic [3:0] ef0,
                     input logic er1, input logic ef1,
                     input logic er2, input logic ef2);
    exp_t e;
    @(negedge clk);
    rst_n = rst;
    s0    = s0v;
    s1    = s1v;
    s2    = s2v;
    e.tag = tag;
    e.r0  = er0;
    e.f0  = ef0;
    e.r1  = er1;
    e.f1  = ef1;
    e.r2  = er2;
    e.f2  = ef2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk4({e.tag, ".w4_rise"}, r0, e.r0);
    chk4({e.tag, ".w4_fall"}, f0, e.f0);
    chk1({e.tag, ".rl1_rise"}, r1, e.r1);
    chk1({e.tag, ".rl1_fall"}, f1, e.f1);
    chk1({e.tag, ".s2_rise"}, r2, e.r2);
    chk1({e.tag, ".s2_fall"}, f2, e.f2);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    s0    = 4'b0000;
    s1    = 1'b0;
    s2    = 1'b0;

    // Hold reset with inputs toggling: no output activity.
    cyc("rst0", 1'b0, 4'b1111, 1'b1, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rst1", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rst2", 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Release with bit 0 high against RESET_LEVEL=0 (one rise).
    // Release with s1 high against RESET_LEVEL=1 (no pulse).
    cyc("rel", 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rel_hold", 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single fall, then single rise held for ten edges, then fall.
    cyc("fall0", 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("low", 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rise", 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc("high_hold", 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc("drop", 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("low_hold", 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Toggle every cycle: pulses alternate and never coincide.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        cyc("toggle_up", 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        cyc("toggle_dn", 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end

    // Multi-bit: independent, simultaneous edges on different bits.
    cyc("mb_1010", 1'b1, 4'b1010, 1'b1, 1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mb_0110", 1'b1, 4'b0110, 1'b1, 1'b0, 4'b0100, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mb_hold", 1'b1, 4'b0110, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mb_0000", 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two-stage synchronizer: the pulse lands two edges later and is one cycle wide.
    cyc("s2_rise_k0", 1'b1, 4'b0, 1'b1, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("s2_rise_k1", 1'b1, 4'b0, 1'b1, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("s2_rise_k2", 1'b1, 4'b0, 1'b1, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("s2_rise_k3", 1'b1, 4'b0, 1'b1, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("s2_fall_k0", 1'b1, 4'b0, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("s2_fall_k1", 1'b1, 4'b0, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("s2_fall_k2", 1'b1, 4'b0, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("s2_fall_k3", 1'b1, 4'b0, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Assert reset mid-pulse: the outputs clear before the next edge.
    cyc("pre_arst", 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst.w4_rise", r0, 4'b0000);
    chk4("async_rst.w4_fall", f0, 4'b0000);

    // While in reset, s1 goes low. On release, s1 differs from RESET_LEVEL=1,
    // which gives one falling pulse. Bit 0 of u_w4 also rises again.
    cyc("arst_hold0", 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("arst_hold1", 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rel2", 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("rel2_hold", 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_edge_detection
`default_nettype wire
